// File: rtl/node_inject_queue.sv
// Local-injection FIFO feeding one nodeRouter local port: holds the oldest flit
// on portl_ci until acked, and flags the head flit when it has waited too long.
module node_inject_queue #(
  parameter int FLIT_W       = 144,
  parameter int DEPTH        = 4,
  parameter int PTR_W        = 2,
  parameter int VALID_BIT    = 12,
  parameter int STARVE_LIMIT = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [FLIT_W-1:0] enq_flit,
  input  logic              enq_valid,
  output logic              enq_ready,
  output logic              enq_err,
  output logic [FLIT_W-1:0] portl_ci,
  input  logic              portl_ack,
  output logic [PTR_W:0]    count,
  output logic              starve
);

  localparam logic [PTR_W:0] FULL_COUNT = (PTR_W+1)'(DEPTH);
  localparam logic [7:0]     WAIT_MAX   = 8'(STARVE_LIMIT);

  logic [FLIT_W-1:0] mem [DEPTH];

  logic [PTR_W-1:0] head_reg, head_next;
  logic [PTR_W-1:0] tail_reg, tail_next;
  logic [PTR_W:0]   count_reg, count_next;
  logic [7:0]       wait_reg, wait_next;
  logic             enq_err_reg, enq_err_next;
  logic             starve_reg, starve_next;

  logic not_empty;
  logic enq_attempt;
  logic enq_fire;
  logic pop_fire;

  assign not_empty   = (count_reg != '0);
  assign enq_ready   = (count_reg != FULL_COUNT);
  assign enq_attempt = enq_valid && enq_ready;
  assign enq_fire    = enq_attempt && enq_flit[VALID_BIT];
  assign pop_fire    = portl_ack && not_empty;

  // Storage carries no reset; the zero-forcing on portl_ci hides stale entries.
  always_ff @(posedge clk) begin
    if (enq_fire) begin
      mem[tail_reg] <= enq_flit;
    end
  end

  always_comb begin
    head_next    = head_reg;
    tail_next    = tail_reg;
    count_next   = count_reg;
    wait_next    = wait_reg;
    enq_err_next = enq_attempt && !enq_flit[VALID_BIT];

    if (enq_fire) begin
      tail_next = tail_reg + 1'b1;
    end
    if (pop_fire) begin
      head_next = head_reg + 1'b1;
    end

    if (enq_fire && !pop_fire) begin
      count_next = count_reg + 1'b1;
    end else if (pop_fire && !enq_fire) begin
      count_next = count_reg - 1'b1;
    end

    if (pop_fire || !not_empty) begin
      wait_next = '0;
    end else if (wait_reg != WAIT_MAX) begin
      wait_next = wait_reg + 1'b1;
    end

    starve_next = (wait_next == WAIT_MAX);
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      head_reg    <= '0;
      tail_reg    <= '0;
      count_reg   <= '0;
      wait_reg    <= '0;
      enq_err_reg <= 1'b0;
      starve_reg  <= 1'b0;
    end else begin
      head_reg    <= head_next;
      tail_reg    <= tail_next;
      count_reg   <= count_next;
      wait_reg    <= wait_next;
      enq_err_reg <= enq_err_next;
      starve_reg  <= starve_next;
    end
  end

  assign portl_ci = not_empty ? mem[head_reg] : '0;
  assign count    = count_reg;
  assign enq_err  = enq_err_reg;
  assign starve   = starve_reg;

endmodule

// File: tb/tb_node_inject_queue.sv
// Directed bench for node_inject_queue: scoreboard queue of expected flits,
// immediate-assertion checks on every cycle's outputs.
module tb_node_inject_queue;

  localparam int FLIT_W = 144;
  localparam int DEPTH  = 4;
  localparam int LIMIT  = 16;

  logic              clk = 1'b0;
  logic              rst;
  logic [FLIT_W-1:0] enq_flit;
  logic              enq_valid;
  logic              enq_ready;
  logic              enq_err;
  logic [FLIT_W-1:0] portl_ci;
  logic              portl_ack;
  logic [2:0]        count;
  logic              starve;

  node_inject_queue #(
    .FLIT_W(FLIT_W), .DEPTH(DEPTH), .PTR_W(2), .VALID_BIT(12), .STARVE_LIMIT(LIMIT)
  ) dut (
    .clk(clk), .rst(rst), .enq_flit(enq_flit), .enq_valid(enq_valid),
    .enq_ready(enq_ready), .enq_err(enq_err), .portl_ci(portl_ci),
    .portl_ack(portl_ack), .count(count), .starve(starve)
  );

  always #5 clk = ~clk;

  logic [FLIT_W-1:0] sb[$];
  int checks = 0;
  int errors = 0;
  int exp_wait = 0;

  localparam logic [FLIT_W-1:0] F1852 = 144'h0a00000000000000000000000000000f1852;
  localparam logic [FLIT_W-1:0] F1853 = 144'h0a00000000000000000000000000000f1853;
  localparam logic [FLIT_W-1:0] F1857 = 144'h0a00000000000000000000000000000f1857;
  localparam logic [FLIT_W-1:0] F1858 = 144'h0a00000000000000000000000000000f1858;
  localparam logic [FLIT_W-1:0] F1859 = 144'h0a00000000000000000000000000000f1859;
  localparam logic [FLIT_W-1:0] F2A11 = 144'h55aa0000000000000000000012345678fa11;
  localparam logic [FLIT_W-1:0] F3F00 = 144'hffffffffffffffffffffffffffffffff3f00;

  task automatic chk(input string tag, input logic [FLIT_W-1:0] obs, input logic [FLIT_W-1:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // One clock cycle of stimulus; checks pre-edge outputs, then post-edge outputs.
  task automatic cycle(input logic en, input logic [FLIT_W-1:0] flit, input logic ack);
    int  cnt_before;
    bit  do_pop, do_enq, exp_err;
    cnt_before = sb.size();
    chk("enq_ready", {143'd0, enq_ready}, {143'd0, cnt_before != DEPTH});
    if (cnt_before > 0) chk("head_flit", portl_ci, sb[0]);
    else                chk("idle_ci", portl_ci, '0);
    do_pop  = ack && (cnt_before > 0);
    do_enq  = en && (cnt_before != DEPTH) && flit[12];
    exp_err = en && (cnt_before != DEPTH) && !flit[12];
    enq_valid = en;
    enq_flit  = flit;
    portl_ack = ack;
    @(posedge clk);
    #1;
    if (do_pop) void'(sb.pop_front());
    if (do_enq) sb.push_back(flit);
    if (do_pop || cnt_before == 0) exp_wait = 0;
    else if (exp_wait < LIMIT)     exp_wait++;
    enq_valid = 1'b0;
    enq_flit  = '0;
    portl_ack = 1'b0;
    $display("cycle en=%0b ack=%0b flit=%h count=%0d enq_err=%0b starve=%0b",
             en, ack, flit, count, enq_err, starve);
    chk("count", {141'd0, count}, FLIT_W'(sb.size()));
    chk("enq_err", {143'd0, enq_err}, {143'd0, exp_err});
    chk("starve", {143'd0, starve}, {143'd0, exp_wait == LIMIT});
  endtask

  initial begin
    rst = 1'b0;
    enq_flit = '0;
    enq_valid = 1'b0;
    portl_ack = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    // Reset state
    chk("rst_ci", portl_ci, '0);
    chk("rst_count", {141'd0, count}, '0);
    chk("rst_ready", {143'd0, enq_ready}, 144'd1);
    chk("rst_starve", {143'd0, starve}, '0);
    rst = 1'b1;
    cycle(0, '0, 0);

    // Single flit, no bypass, then ack
    cycle(1, F1853, 0);
    chk("appear_after_enq", portl_ci, F1853);
    cycle(0, '0, 1);
    chk("empty_after_ack", portl_ci, '0);

    // Fill to full, fifth rejected, drain in order
    cycle(1, F1852, 0);
    cycle(1, F1853, 0);
    cycle(1, F1857, 0);
    cycle(1, F1858, 0);
    chk("full_ready", {143'd0, enq_ready}, '0);
    cycle(1, F1859, 0);
    repeat (4) cycle(0, '0, 1);
    cycle(0, '0, 0);

    // Invalid flit rejected with one-cycle error pulse
    cycle(1, '0, 0);
    cycle(0, '0, 0);
    cycle(1, F3F00, 1);
    cycle(0, '0, 0);

    // Full with simultaneous enqueue and ack, then steady-state push+pop
    cycle(1, F3F00, 0);
    cycle(1, F1857, 0);
    cycle(1, F2A11, 0);
    cycle(1, F1852, 0);
    cycle(1, F1859, 1);
    cycle(0, '0, 1);
    cycle(1, F1858, 1);
    cycle(1, F1853, 1);
    repeat (3) cycle(0, '0, 1);

    // Starvation on a held head flit
    cycle(1, F2A11, 0);
    for (int i = 1; i <= LIMIT + 4; i++) begin
      cycle(0, '0, 0);
      chk("starve_timing", {143'd0, starve}, {143'd0, i >= LIMIT});
    end
    cycle(0, '0, 1);
    chk("starve_clear", {143'd0, starve}, '0);

    // Asynchronous reset mid-run
    cycle(1, F1852, 0);
    cycle(1, F1853, 0);
    #2;
    rst = 1'b0;
    #1;
    chk("async_rst_count", {141'd0, count}, '0);
    chk("async_rst_ci", portl_ci, '0);
    chk("async_rst_ready", {143'd0, enq_ready}, 144'd1);
    sb.delete();
    exp_wait = 0;
    portl_ack = 1'b1;
    @(posedge clk);
    #1;
    portl_ack = 1'b0;
    chk("rst_ack_ignored", {141'd0, count}, '0);
    rst = 1'b1;
    cycle(1, F1858, 0);
    cycle(0, '0, 1);
    cycle(0, '0, 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
